perm_write_ctrl: RTL
====================

# perm_write_ctrl

Permission write controller for the protected-read path: the writer side that drives the set/reset inputs of the per-object permission flip-flops. It accepts grant/revoke requests over a valid/ready handshake, checks the requester's key against a per-object owner-key table, emits a single-cycle set or reset pulse to the addressed permission flop, and returns a status response. Three consecutive key failures lock the controller out for a fixed interval.

## Interface
- NUM_OBJ, 16, number of protected objects and permission flops
- ID_W, 4, object-id width; must satisfy 2^ID_W >= NUM_OBJ
- KEY_W, 8, owner-key width
- MAX_FAILS, 3, consecutive key failures that trigger lockout
- LOCK_CYCLES, 64, lockout duration in clk cycles (>= 1)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; all state cleared immediately on assertion
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_id  in  ID_W  target object
- req_grant  in  1  1 = grant (set), 0 = revoke (reset)
- req_key  in  KEY_W  requester key
- key_wr  in  1  owner-key table write strobe
- key_wr_id  in  ID_W  table entry to write
- key_wr_data  in  KEY_W  new owner key
- perm_set  out  NUM_OBJ  one-cycle set pulses to the permission flops
- perm_reset  out  NUM_OBJ  one-cycle reset pulses to the permission flops
- perm_shadow  out  NUM_OBJ  controller copy of the permission state
- rsp_valid  out  1  response present
- rsp_ok  out  1  1 = applied, 0 = rejected
- rsp_ready  in  1  response consumer ready
- locked  out  1  lockout active

## Operation
- Reset values: req_ready 0 while reset is high, 1 in the first cycle after release (IDLE); perm_set, perm_reset, perm_shadow, rsp_valid, rsp_ok, and locked all 0; fail counter 0; lock counter 0; all key-table entries 0.
- IDLE: req_ready = 1. On req_valid & req_ready, capture id, grant, and key, then go to CHECK.
- CHECK: pass if captured id < NUM_OBJ and key == table[id].
  - Pass: go to APPLY.
  - Fail: increment the fail counter (saturating at MAX_FAILS), then go to RESP with rsp_ok = 0.
- APPLY: assert perm_set[id] (grant) or perm_reset[id] (revoke) for exactly one cycle. Update perm_shadow[id]. Clear the fail counter. Go to RESP with rsp_ok = 1.
- RESP: rsp_valid = 1, and rsp_valid and rsp_ok hold stable until rsp_ready. On handshake, go to LOCK if the fail counter == MAX_FAILS, otherwise go to IDLE.
- LOCK: locked = 1 and req_ready = 0. The lock counter counts LOCK_CYCLES cycles. On expiry, clear the fail counter and the lock counter, then go to IDLE.
- Pulse rules:
  - At most one bit of perm_set | perm_reset is high in any cycle.
  - perm_set and perm_reset are never both high for the same index; the downstream 11 case is unreachable.
  - Repeated grants to an already-set object still pulse; the result is idempotent.
- Key table: key_wr writes in any state, including LOCK. A write with key_wr_id >= NUM_OBJ is ignored.
- Simultaneous key_wr and CHECK on the same id: the compare uses the pre-write value.
- req_ready is low in CHECK, APPLY, RESP, and LOCK. Only one request is in flight at a time; there is no queuing.

## Timing
- Handshake accepted at edge N:
  - CHECK during cycle N..N+1.
  - Pass: perm pulse in cycle N+1..N+2, rsp_valid from N+2.
  - Fail: rsp_valid from N+1.
- Minimum request-to-request spacing: 4 cycles on success, 3 on failure (rsp_ready held high).
- Lockout: locked rises the cycle after the failing response handshake. It stays high for exactly LOCK_CYCLES cycles, and req_ready rises the cycle after locked falls.
- Asynchronous reset mid-operation (any state) clears everything: no pulse completes, the pending response is dropped, and the key table returns to 0.

## Structure
- Shared package perm_pkg: FSM state encoding (IDLE, CHECK, APPLY, RESP, LOCK) and the response-code constants.
- Sub-module perm_key_table: NUM_OBJ x KEY_W register file with async-reset-to-zero, one write port, and one combinational read port.
- The FSM, fail counter, lock counter, and pulse decode live in the top module.

## Test plan
- Reset, then load key[5]=0xA7; request id=5, grant=1, key=0xA7 -> perm_set = 0x0020 for exactly one cycle, perm_shadow[5]=1, rsp_valid at N+2 with rsp_ok=1.
- Revoke id=5 with key 0xA7 -> perm_reset = 0x0020 for exactly one cycle, perm_shadow[5]=0; perm_set stays 0 throughout.
- Three wrong-key requests to id=2 -> three responses with rsp_ok=0, then locked=1 for exactly 64 cycles with req_ready=0; a correct request issued afterwards succeeds.
- Two failures, then one success, then two failures -> no lockout (fail counter cleared by the success).
- key_wr id=3 to 0x55 in the same cycle as CHECK of id=3 with key 0x55 (old entry 0x00) -> rsp_ok=0. Request id=15 with NUM_OBJ=12 -> rsp_ok=0 and no pulse.
- Hold rsp_ready=0 for 10 cycles -> rsp_valid and rsp_ok stable, req_ready=0. Assert reset during APPLY -> all outputs go to 0 immediately and no pulse appears after release.

Source files
------------

// File: rtl/perm_pkg.sv
// Shared definitions for the permission write controller: FSM state
// encoding and response codes.
package perm_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CHECK = 3'd1;
  localparam logic [2:0] ST_APPLY = 3'd2;
  localparam logic [2:0] ST_RESP  = 3'd3;
  localparam logic [2:0] ST_LOCK  = 3'd4;

  localparam logic RSP_OK     = 1'b1;
  localparam logic RSP_REJECT = 1'b0;

endpackage

// File: rtl/perm_key_table.sv
// Owner-key register file: one write port, one combinational read port,
// async reset to zero. Writes to ids at or beyond NUM_OBJ are dropped.
module perm_key_table #(
  parameter int NUM_OBJ = 16,
  parameter int ID_W    = 4,
  parameter int KEY_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [ID_W-1:0]  wr_id,
  input  logic [KEY_W-1:0] wr_data,
  input  logic [ID_W-1:0]  rd_id,
  output logic [KEY_W-1:0] rd_data
);

  logic [KEY_W-1:0] mem [NUM_OBJ];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_OBJ; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        if (wr && (wr_id == ID_W'(i))) mem[i] <= wr_data;
      end
    end
  end

  // Out-of-range ids read as zero; the controller rejects them anyway.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (rd_id == ID_W'(i)) rd_data = mem[i];
    end
  end

endmodule

// File: rtl/perm_write_ctrl.sv
// Permission write controller: key-checked grant/revoke requests become
// single-cycle set/reset pulses, with lockout after repeated key failures.
module perm_write_ctrl
  import perm_pkg::*;
#(
  parameter int NUM_OBJ     = 16,
  parameter int ID_W        = 4,
  parameter int KEY_W       = 8,
  parameter int MAX_FAILS   = 3,
  parameter int LOCK_CYCLES = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ID_W-1:0]    req_id,
  input  logic               req_grant,
  input  logic [KEY_W-1:0]   req_key,
  input  logic               key_wr,
  input  logic [ID_W-1:0]    key_wr_id,
  input  logic [KEY_W-1:0]   key_wr_data,
  output logic [NUM_OBJ-1:0] perm_set,
  output logic [NUM_OBJ-1:0] perm_reset,
  output logic [NUM_OBJ-1:0] perm_shadow,
  output logic               rsp_valid,
  output logic               rsp_ok,
  input  logic               rsp_ready,
  output logic               locked
);

  // Handshakes: a request transfers on a rising edge where req_valid and
  // req_ready are both high; a response transfers where rsp_valid and
  // rsp_ready are both high. rsp_valid/rsp_ok hold until that transfer.

  localparam int FAIL_W = $clog2(MAX_FAILS + 1);
  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);

  logic [2:0]         state;
  logic [ID_W-1:0]    id_q;
  logic               grant_q;
  logic [KEY_W-1:0]   key_q;
  logic [FAIL_W-1:0]  fail_cnt;
  logic [LOCK_W-1:0]  lock_cnt;
  logic               rsp_ok_q;
  logic [NUM_OBJ-1:0] shadow_q;
  logic [KEY_W-1:0]   tbl_key;
  logic [NUM_OBJ-1:0] id_onehot;
  logic               id_ok;
  logic               check_pass;

  perm_key_table #(
    .NUM_OBJ (NUM_OBJ),
    .ID_W    (ID_W),
    .KEY_W   (KEY_W)
  ) u_key_table (
    .clk     (clk),
    .reset   (reset),
    .wr      (key_wr),
    .wr_id   (key_wr_id),
    .wr_data (key_wr_data),
    .rd_id   (id_q),
    .rd_data (tbl_key)
  );

  // An all-zero decode doubles as the out-of-range flag.
  always_comb begin
    id_onehot = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (id_q == ID_W'(i)) id_onehot[i] = 1'b1;
    end
  end

  assign id_ok      = |id_onehot;
  assign check_pass = id_ok && (key_q == tbl_key);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      id_q     <= '0;
      grant_q  <= 1'b0;
      key_q    <= '0;
      fail_cnt <= '0;
      lock_cnt <= '0;
      rsp_ok_q <= 1'b0;
      shadow_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            id_q    <= req_id;
            grant_q <= req_grant;
            key_q   <= req_key;
            state   <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (check_pass) begin
            state <= ST_APPLY;
          end else begin
            if (fail_cnt != FAIL_W'(MAX_FAILS)) fail_cnt <= fail_cnt + 1'b1;
            rsp_ok_q <= RSP_REJECT;
            state    <= ST_RESP;
          end
        end
        ST_APPLY: begin
          shadow_q <= grant_q ? (shadow_q | id_onehot) : (shadow_q & ~id_onehot);
          fail_cnt <= '0;
          rsp_ok_q <= RSP_OK;
          state    <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_ok_q <= 1'b0;
            state    <= (fail_cnt == FAIL_W'(MAX_FAILS)) ? ST_LOCK : ST_IDLE;
          end
        end
        ST_LOCK: begin
          if (lock_cnt == LOCK_W'(LOCK_CYCLES - 1)) begin
            lock_cnt <= '0;
            fail_cnt <= '0;
            state    <= ST_IDLE;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Pulses decode straight from state so reset kills them immediately.
  assign req_ready   = (state == ST_IDLE) && !reset;
  assign perm_set    = ((state == ST_APPLY) && grant_q)  ? id_onehot : '0;
  assign perm_reset  = ((state == ST_APPLY) && !grant_q) ? id_onehot : '0;
  assign perm_shadow = shadow_q;
  assign rsp_valid   = (state == ST_RESP);
  assign rsp_ok      = rsp_ok_q;
  assign locked      = (state == ST_LOCK);

endmodule
